fetch_stage: RTL and testbench



---
 rtl/fetch_pkg.sv | 21 ++
 rtl/if_id_reg.sv | 29 ++
 rtl/fetch_stage.sv | 144 ++++++++++++++
 tb/tb_fetch_stage.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch stage: FSM states, bubble word,
// and the IF/ID pipeline register bundle.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        HOLD   = 2'd2,
        SQUASH = 2'd3
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] instr;
        logic        valid;
    } if_id_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register. Bubble takes precedence over load; neither holds.
module if_id_reg #(
    parameter logic [31:0] NOP_INSTR = fetch_pkg::NOP_INSTR
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load,
    input  logic             bubble,
    input  fetch_pkg::if_id_t d,
    output fetch_pkg::if_id_t q
);

    import fetch_pkg::*;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            q.pc    <= 32'h0000_0000;
            q.pc4   <= 32'h0000_0000;
            q.instr <= NOP_INSTR;
            q.valid <= 1'b0;
        end else if (bubble) begin
            q.instr <= NOP_INSTR;
            q.valid <= 1'b0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// IF stage: PC register, imem req/ack fetch FSM and IF/ID register control.
//
// state  | meaning
// IDLE   | one quiet cycle after reset, no request
// FETCH  | request at pc_q; ack loads IF/ID (or the buffer when stalled)
// HOLD   | word accepted during stall, parked in buffer until stall drops
// SQUASH | redirect hit an outstanding request; wait for its ack, discard it
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] if_id_pc_o,
    output logic [31:0] if_id_pc4_o,
    output logic [31:0] if_id_instr_o,
    output logic        if_id_valid_o
);

    import fetch_pkg::*;

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  squash_addr_q, squash_addr_d;
    logic [31:0]  buf_pc_q, buf_pc_d;
    logic [31:0]  buf_instr_q, buf_instr_d;
    logic         load, bubble;
    if_id_t       load_data, if_id_q;
    logic [31:0]  redirect_tgt;
    logic [31:0]  pc_plus4;
    logic         unused_low_bits;

    assign redirect_tgt    = {redirect_pc_i[31:2], 2'b00};
    assign pc_plus4        = pc_q + 32'd4;
    assign unused_low_bits = &{1'b0, redirect_pc_i[1:0]};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            pc_q          <= {RESET_PC[31:2], 2'b00};
            squash_addr_q <= 32'h0000_0000;
            buf_pc_q      <= 32'h0000_0000;
            buf_instr_q   <= 32'h0000_0000;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            squash_addr_q <= squash_addr_d;
            buf_pc_q      <= buf_pc_d;
            buf_instr_q   <= buf_instr_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        squash_addr_d = squash_addr_q;
        buf_pc_d      = buf_pc_q;
        buf_instr_d   = buf_instr_q;
        load          = 1'b0;
        bubble        = 1'b0;
        load_data     = '0;

        unique case (state_q)
            IDLE: begin
                state_d = FETCH;
                if (redirect_i) begin
                    bubble = 1'b1;
                    pc_d   = redirect_tgt;
                end
            end
            FETCH: begin
                if (redirect_i) begin
                    bubble = 1'b1;
                    pc_d   = redirect_tgt;
                    if (!imem_ack_i) begin
                        squash_addr_d = pc_q;
                        state_d       = SQUASH;
                    end
                end else if (imem_ack_i) begin
                    pc_d = pc_plus4;
                    if (stall_i) begin
                        buf_pc_d    = pc_q;
                        buf_instr_d = imem_rdata_i;
                        state_d     = HOLD;
                    end else begin
                        load      = 1'b1;
                        load_data = '{pc: pc_q, pc4: pc_plus4, instr: imem_rdata_i, valid: 1'b1};
                    end
                end else if (!stall_i) begin
                    bubble = 1'b1;
                end
            end
            HOLD: begin
                if (redirect_i) begin
                    bubble  = 1'b1;
                    pc_d    = redirect_tgt;
                    state_d = FETCH;
                end else if (!stall_i) begin
                    load      = 1'b1;
                    load_data = '{pc: buf_pc_q, pc4: buf_pc_q + 32'd4, instr: buf_instr_q, valid: 1'b1};
                    state_d   = FETCH;
                end
            end
            SQUASH: begin
                // The old address stays on the bus; only the redirect target moves.
                if (redirect_i) begin
                    bubble = 1'b1;
                    pc_d   = redirect_tgt;
                end else if (!stall_i) begin
                    bubble = 1'b1;
                end
                if (imem_ack_i) begin
                    state_d = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign imem_req_o  = (state_q == FETCH) || (state_q == SQUASH);
    assign imem_addr_o = (state_q == SQUASH) ? squash_addr_q : pc_q;

    if_id_reg #(.NOP_INSTR(NOP_INSTR)) u_if_id (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .load   (load),
        .bubble (bubble),
        .d      (load_data),
        .q      (if_id_q)
    );

    assign if_id_pc_o    = if_id_q.pc;
    assign if_id_pc4_o   = if_id_q.pc4;
    assign if_id_instr_o = if_id_q.instr;
    assign if_id_valid_o = if_id_q.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage with a combinational instruction memory
// whose ack timing is scripted per scenario.
module tb_fetch_stage;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_rdata_i;
    logic [31:0] if_id_pc_o;
    logic [31:0] if_id_pc4_o;
    logic [31:0] if_id_instr_o;
    logic        if_id_valid_o;

    int errors = 0;
    int checks = 0;

    localparam logic [31:0] NOP = 32'h0000_0013;

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    assign imem_rdata_i = mem_word(imem_addr_o);

    fetch_stage dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_ack_i    (imem_ack_i),
        .imem_rdata_i  (imem_rdata_i),
        .if_id_pc_o    (if_id_pc_o),
        .if_id_pc4_o   (if_id_pc4_o),
        .if_id_instr_o (if_id_instr_o),
        .if_id_valid_o (if_id_valid_o)
    );

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk_bus(input string name, input logic req, input logic [31:0] addr);
        checks++;
        if (imem_req_o !== req || (req && imem_addr_o !== addr)) begin
            errors++;
            $display("FAIL %s: req=%b addr=%h, want req=%b addr=%h", name, imem_req_o, imem_addr_o, req, addr);
        end
    endtask

    task automatic chk_ifid(input string name, input logic valid, input logic [31:0] pc,
                            input logic [31:0] pc4, input logic [31:0] instr);
        checks++;
        if (if_id_valid_o !== valid || if_id_instr_o !== instr ||
            (valid && (if_id_pc_o !== pc || if_id_pc4_o !== pc4))) begin
            errors++;
            $display("FAIL %s: valid=%b pc=%h pc4=%h instr=%h, want valid=%b pc=%h pc4=%h instr=%h",
                     name, if_id_valid_o, if_id_pc_o, if_id_pc4_o, if_id_instr_o, valid, pc, pc4, instr);
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0; imem_ack_i = 1'b1;
        step(); step();
        chk_bus("reset_bus", 1'b0, 32'h0);
        checks++;
        if (if_id_valid_o !== 1'b0 || if_id_instr_o !== NOP || if_id_pc_o !== 32'h0 || if_id_pc4_o !== 32'h0) begin
            errors++;
            $display("FAIL reset_ifid: valid=%b instr=%h pc=%h pc4=%h, want 0 %h 0 0",
                     if_id_valid_o, if_id_instr_o, if_id_pc_o, if_id_pc4_o, NOP);
        end
        rst_i = 1'b0;
    endtask

    task automatic test_zero_wait();
        step();
        chk_bus("zw_first_req", 1'b1, 32'h0);
        chk_ifid("zw_first_ifid", 1'b0, 32'h0, 32'h0, NOP);
        step();
        chk_bus("zw_req4", 1'b1, 32'h4);
        chk_ifid("zw_ifid0", 1'b1, 32'h0, 32'h4, mem_word(32'h0));
        step();
        chk_bus("zw_req8", 1'b1, 32'h8);
        chk_ifid("zw_ifid4", 1'b1, 32'h4, 32'h8, mem_word(32'h4));
        step();
        chk_bus("zw_reqC", 1'b1, 32'hC);
        chk_ifid("zw_ifid8", 1'b1, 32'h8, 32'hC, mem_word(32'h8));
    endtask

    task automatic test_delayed_ack();
        imem_ack_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            chk_bus("dly_hold_addr", 1'b1, 32'hC);
            chk_ifid("dly_bubble", 1'b0, 32'h0, 32'h0, NOP);
        end
        imem_ack_i = 1'b1;
        step();
        chk_bus("dly_next_req", 1'b1, 32'h10);
        chk_ifid("dly_word", 1'b1, 32'hC, 32'h10, mem_word(32'hC));
    endtask

    task automatic test_stall_hold();
        stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_bus("stall_no_req", 1'b0, 32'h0);
            chk_ifid("stall_ifid_held", 1'b1, 32'hC, 32'h10, mem_word(32'hC));
        end
        stall_i = 1'b0;
        step();
        chk_ifid("stall_release_word", 1'b1, 32'h10, 32'h14, mem_word(32'h10));
        chk_bus("stall_next_req", 1'b1, 32'h14);
    endtask

    task automatic test_redirect_outstanding();
        imem_ack_i = 1'b0; redirect_i = 1'b1; redirect_pc_i = 32'h0000_0103;
        step();
        redirect_i = 1'b0;
        chk_bus("sq_addr_stable", 1'b1, 32'h14);
        chk_ifid("sq_bubble", 1'b0, 32'h0, 32'h0, NOP);
        step();
        chk_bus("sq_addr_stable2", 1'b1, 32'h14);
        imem_ack_i = 1'b1;
        step();
        chk_ifid("sq_word_dropped", 1'b0, 32'h0, 32'h0, NOP);
        chk_bus("sq_target_req", 1'b1, 32'h100);
        step();
        chk_ifid("sq_target_word", 1'b1, 32'h100, 32'h104, mem_word(32'h100));
        chk_bus("sq_target_next", 1'b1, 32'h104);
    endtask

    task automatic test_redirect_stall();
        redirect_i = 1'b1; stall_i = 1'b1; redirect_pc_i = 32'h0000_0200;
        step();
        redirect_i = 1'b0; stall_i = 1'b0;
        chk_ifid("rs_bubble", 1'b0, 32'h0, 32'h0, NOP);
        chk_bus("rs_target_req", 1'b1, 32'h200);
        step();
        chk_ifid("rs_target_word", 1'b1, 32'h200, 32'h204, mem_word(32'h200));
    endtask

    task automatic test_wrap();
        redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC;
        step();
        redirect_i = 1'b0;
        chk_bus("wrap_top_req", 1'b1, 32'hFFFF_FFFC);
        step();
        chk_ifid("wrap_top_word", 1'b1, 32'hFFFF_FFFC, 32'h0, mem_word(32'hFFFF_FFFC));
        chk_bus("wrap_zero_req", 1'b1, 32'h0);
    endtask

    task automatic test_reset_mid_squash();
        imem_ack_i = 1'b0; redirect_i = 1'b1; redirect_pc_i = 32'h0000_0300;
        step();
        redirect_i = 1'b0;
        chk_bus("rsq_squash_addr", 1'b1, 32'h0);
        #2 rst_i = 1'b1;
        #1;
        chk_bus("rsq_async_req", 1'b0, 32'h0);
        chk_ifid("rsq_async_ifid", 1'b0, 32'h0, 32'h0, NOP);
        imem_ack_i = 1'b1;
        step();
        rst_i = 1'b0;
        step();
        chk_bus("rsq_first_req", 1'b1, 32'h0);
        step();
        chk_ifid("rsq_first_word", 1'b1, 32'h0, 32'h4, mem_word(32'h0));
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_delayed_ack();
        test_stall_hold();
        test_redirect_outstanding();
        test_redirect_stall();
        test_wrap();
        test_reset_mid_squash();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
